// File: rtl/echo_fifo_pkg.sv
// Register map and bit positions shared by the echo FIFO top and its bench.
package echo_fifo_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_PCNT = 2'd3;

  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 18;
  localparam int STAT_UNF   = 19;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_CLRERR = 1;
  localparam int CTRL_INV    = 2;

endpackage

// File: rtl/echo_fifo_buf.sv
// Circular buffer: storage, pointers and occupancy count with push/pop/flush.
module echo_fifo_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from the count so equal pointers are never ambiguous.
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Contents survive reset and flush; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/echo_fifo.sv
// Bus-attached echo FIFO: data/status/control/push-counter registers around a buffer.
module echo_fifo
  import echo_fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack
);

  logic [WIDTH-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_rd;
  logic             w_wr;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic [31:0]      w_stat;
  logic             w_unused_data;
  logic             r_ovf;
  logic             r_unf;
  logic             r_inv;
  logic [31:0]      r_pcnt;

  assign ack     = stb;
  assign w_rd    = stb & ~we;
  assign w_wr    = stb & we;
  assign w_push  = w_wr & (addr == ADDR_DATA) & ~w_full;
  assign w_pop   = w_rd & (addr == ADDR_DATA) & ~w_empty;
  assign w_flush = w_wr & (addr == ADDR_CTRL) & data_in[CTRL_FLUSH];
  assign w_unused_data = ^data_in;

  echo_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .i_wr_data (data_in[WIDTH-1:0]),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_stat = {12'b0, r_unf, r_ovf, w_full, w_empty, 16'(w_count)};

  always_comb begin
    data_out = '0;
    if (w_rd) begin
      case (addr)
        ADDR_DATA: if (!w_empty) data_out = 32'(w_head ^ {WIDTH{r_inv}});
        ADDR_STAT: data_out = w_stat;
        ADDR_CTRL: data_out = {29'b0, r_inv, 2'b0};
        default:   data_out = r_pcnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_inv  <= 1'b0;
      r_pcnt <= '0;
    end else begin
      if (w_wr && addr == ADDR_DATA && w_full)  r_ovf <= 1'b1;
      if (w_rd && addr == ADDR_DATA && w_empty) r_unf <= 1'b1;
      if (w_wr && addr == ADDR_CTRL) begin
        if (data_in[CTRL_CLRERR]) begin
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
        end
        r_inv <= data_in[CTRL_INV];
      end
      if (w_push) r_pcnt <= r_pcnt + 32'd1;
      else if (w_wr && addr == ADDR_PCNT) r_pcnt <= '0;
    end
  end

endmodule

// File: tb/tb_echo_fifo.sv
// Self-checking bench for echo_fifo with a reference-model scoreboard.
module tb_echo_fifo;
  import echo_fifo_pkg::*;

  localparam int W = 16;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  int total = 0;
  int bad = 0;

  // Reference model state.
  logic [W-1:0] exp_q[$];
  logic         m_ovf;
  logic         m_unf;
  logic         m_inv;
  logic [31:0]  m_pcnt;

  echo_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_inv = 1'b0;
    m_pcnt = '0;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      ADDR_DATA: begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(d[W-1:0]);
          m_pcnt = m_pcnt + 32'd1;
        end else m_ovf = 1'b1;
      end
      ADDR_CTRL: begin
        if (d[0]) exp_q.delete();
        if (d[1]) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        m_inv = d[2];
      end
      ADDR_PCNT: m_pcnt = '0;
      default: ;
    endcase
  endtask

  task automatic model_read_data(output logic [31:0] e);
    logic [W-1:0] v;
    if (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      e = 32'(v ^ {W{m_inv}});
    end else begin
      e = '0;
      m_unf = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(exp_q.size());
    s[STAT_EMPTY] = (exp_q.size() == 0);
    s[STAT_FULL]  = (exp_q.size() == DEPTH);
    s[STAT_OVF]   = m_ovf;
    s[STAT_UNF]   = m_unf;
    return s;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1;
    we = 1'b1;
    addr = a;
    data_in = d;
    @(posedge clk);
    #1;
    stb = 1'b0;
    we = 1'b0;
    data_in = '0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic k);
    @(negedge clk);
    stb = 1'b1;
    we = 1'b0;
    addr = a;
    #2;
    d = data_out;
    k = ack;
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic k;
    rst = 1'b1;
    stb = 1'b0;
    we = 1'b0;
    addr = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    total++;
    if (data_out !== 32'h0 || ack !== 1'b0) begin
      bad++;
      $display("FAIL idle_outputs got=%h/%b exp=0/0", data_out, ack);
    end
    bus_read(ADDR_STAT, d, k);
    total++;
    if (d !== 32'h0001_0000 || k !== 1'b1) begin
      bad++;
      $display("FAIL reset_status got=%h ack=%b exp=00010000 ack=1", d, k);
    end
    bus_read(ADDR_DATA, d, k);
    model_read_data(d);
    total++;
    if (data_out !== 32'h0 || d !== 32'h0) begin
      bad++;
      $display("FAIL empty_read_model exp=%h", d);
    end
    bus_read(ADDR_STAT, d, k);
    total++;
    if (d !== 32'h0009_0000) begin
      bad++;
      $display("FAIL unf_status got=%h exp=00090000", d);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [31:0] e;
    logic k;
    logic [31:0] vals[3];
    vals[0] = 32'h1111;
    vals[1] = 32'h2222;
    vals[2] = 32'h3333;
    for (int i = 0; i < 3; i++) bus_write(ADDR_DATA, vals[i]);
    for (int i = 0; i < 3; i++) begin
      bus_read(ADDR_DATA, d, k);
      model_read_data(e);
      total++;
      if (d !== e || d !== vals[i]) begin
        bad++;
        $display("FAIL basic_read%0d got=%h exp=%h", i, d, e);
      end
    end
    bus_read(ADDR_STAT, d, k);
    total++;
    if (d !== 32'h0009_0000) begin
      bad++;
      $display("FAIL basic_status got=%h exp=00090000", d);
    end
    bus_read(ADDR_PCNT, d, k);
    total++;
    if (d !== 32'd3) begin
      bad++;
      $display("FAIL basic_pcnt got=%h exp=3", d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [31:0] e;
    logic k;
    bus_write(ADDR_CTRL, 32'h3);
    for (int i = 0; i <= DEPTH; i++) bus_write(ADDR_DATA, 32'hA0 + 32'(i));
    bus_read(ADDR_STAT, d, k);
    total++;
    if (d !== 32'h0006_0008) begin
      bad++;
      $display("FAIL ovf_status got=%h exp=00060008", d);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      bus_read(ADDR_DATA, d, k);
      model_read_data(e);
      total++;
      if (d !== e || (i < DEPTH && d !== 32'hA0 + 32'(i))) begin
        bad++;
        $display("FAIL ovf_read%0d got=%h exp=%h", i, d, e);
      end
    end
  endtask

  task automatic test_invert();
    logic [31:0] d;
    logic [31:0] e;
    logic k;
    bus_write(ADDR_CTRL, 32'h4);
    bus_write(ADDR_DATA, 32'h00F0);
    bus_read(ADDR_DATA, d, k);
    model_read_data(e);
    total++;
    if (d !== e || d !== 32'h0000_FF0F) begin
      bad++;
      $display("FAIL inv_read got=%h exp=%h", d, e);
    end
    bus_read(ADDR_CTRL, d, k);
    total++;
    if (d !== 32'h4) begin
      bad++;
      $display("FAIL ctrl_read got=%h exp=00000004", d);
    end
    bus_write(ADDR_CTRL, 32'h0);
    bus_write(ADDR_DATA, 32'hDEAD_BEEF);
    bus_read(ADDR_DATA, d, k);
    model_read_data(e);
    total++;
    if (d !== e || d !== 32'h0000_BEEF) begin
      bad++;
      $display("FAIL trunc_read got=%h exp=%h", d, e);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    logic [31:0] e;
    logic k;
    bus_write(ADDR_CTRL, 32'h3);
    bus_read(ADDR_DATA, d, k);
    model_read_data(e);
    for (int i = 0; i <= DEPTH; i++) bus_write(ADDR_DATA, 32'h500 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      bus_read(ADDR_DATA, d, k);
      model_read_data(e);
    end
    bus_read(ADDR_STAT, d, k);
    total++;
    if (d !== 32'h000C_0005 || d !== model_status()) begin
      bad++;
      $display("FAIL pre_flush_status got=%h exp=000c0005", d);
    end
    bus_write(ADDR_CTRL, 32'h3);
    bus_read(ADDR_STAT, d, k);
    total++;
    if (d !== 32'h0001_0000) begin
      bad++;
      $display("FAIL flush_status got=%h exp=00010000", d);
    end
    bus_write(ADDR_DATA, 32'h777);
    bus_read(ADDR_DATA, d, k);
    model_read_data(e);
    total++;
    if (d !== e || d !== 32'h777) begin
      bad++;
      $display("FAIL flush_new_word got=%h exp=%h", d, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] e;
    logic k;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) bus_write(ADDR_DATA, 32'($urandom_range(0, 32'hFFFF_FFFF)));
      for (int i = 0; i < 5; i++) begin
        bus_read(ADDR_DATA, d, k);
        model_read_data(e);
        total++;
        if (d !== e) begin
          bad++;
          $display("FAIL wrap_r%0d_%0d got=%h exp=%h", r, i, d, e);
        end
      end
    end
    bus_read(ADDR_STAT, d, k);
    total++;
    if (d !== model_status()) begin
      bad++;
      $display("FAIL wrap_status got=%h exp=%h", d, model_status());
    end
    bus_read(ADDR_PCNT, d, k);
    total++;
    if (d !== m_pcnt) begin
      bad++;
      $display("FAIL wrap_pcnt got=%h exp=%h", d, m_pcnt);
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] d;
    logic [31:0] e;
    logic k;
    bus_write(ADDR_DATA, 32'h1234);
    bus_write(ADDR_DATA, 32'h5678);
    @(negedge clk);
    stb = 1'b1;
    we = 1'b1;
    addr = ADDR_DATA;
    data_in = 32'h55AA;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stb = 1'b0;
    we = 1'b0;
    data_in = '0;
    model_reset();
    bus_read(ADDR_STAT, d, k);
    total++;
    if (d !== 32'h0001_0000) begin
      bad++;
      $display("FAIL rst_mid_status got=%h exp=00010000", d);
    end
    bus_read(ADDR_DATA, d, k);
    model_read_data(e);
    total++;
    if (d !== e) begin
      bad++;
      $display("FAIL rst_mid_read got=%h exp=%h", d, e);
    end
  endtask

  task automatic test_pcnt_clear();
    logic [31:0] d;
    logic [31:0] s;
    logic k;
    bus_write(ADDR_DATA, 32'h1);
    bus_write(ADDR_DATA, 32'h2);
    bus_read(ADDR_PCNT, d, k);
    total++;
    if (d !== m_pcnt || d !== 32'd2) begin
      bad++;
      $display("FAIL pcnt_count got=%h exp=%h", d, m_pcnt);
    end
    bus_write(ADDR_PCNT, 32'hFFFF_FFFF);
    bus_read(ADDR_PCNT, d, k);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL pcnt_clear got=%h exp=0", d);
    end
    s = model_status();
    bus_write(ADDR_STAT, 32'hFFFF_FFFF);
    bus_read(ADDR_STAT, d, k);
    total++;
    if (d !== s) begin
      bad++;
      $display("FAIL stat_write_ignored got=%h exp=%h", d, s);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_invert();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    test_pcnt_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/echo_fifo.md
Name: echo_fifo

Overview:
- Parametrised successor to the two-register echo test device.
- Words written to the data address are buffered in a DEPTH-entry FIFO and returned in order on reads.
- Adds status, sticky error flags, flush, an invert mode and a push counter.
- Sits as an IO-space slave on the processor bus; used to test bus read/write paths and software drivers.

Parameters:
- WIDTH, 16: stored data width in bits, 1..32; read data zero-extended to 32.
- DEPTH, 8: FIFO entries; power of two, >= 2.
- CNT_W (localparam), $clog2(DEPTH)+1: occupancy counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- stb  in  1  bus strobe, one cycle per transaction
- we  in  1  1 = write, 0 = read
- addr  in  2  register select: 0 data, 1 status, 2 control, 3 push counter
- data_in  in  32  write data
- data_out  out  32  read data, combinational, valid while stb & ~we
- ack  out  1  equal to stb; every access completes in its own cycle

Behaviour:
- Reset (rst high at clk edge): read/write pointers 0, count 0, ovf 0, unf 0, inv 0, push counter 0. rst has priority over a simultaneous stb.
- Outputs during reset: data_out 0 unless a read is strobed; ack follows stb.
- data_out is 0 whenever stb is low or we is high.
- Write addr 0:
  - If not full: store data_in[WIDTH-1:0] at wr_ptr, increment wr_ptr mod DEPTH, increment count and push counter (push counter wraps at 2^32).
  - If full: data dropped, ovf <= 1, no pointer, count or counter change.
- Read addr 0:
  - If not empty: data_out = zero-extended head entry, XOR all-ones over WIDTH bits when inv = 1; rd_ptr increments mod DEPTH and count decrements at the clk edge ending the strobe cycle.
  - If empty: data_out = 0, unf <= 1, no state change.
- Read addr 1 (status):
  - bits 15:0 count, zero-extended
  - bit 16 empty (count = 0)
  - bit 17 full (count = DEPTH)
  - bit 18 ovf
  - bit 19 unf
  - bits 31:20 zero
  - No side effects.
- Write addr 1: ignored.
- Write addr 2 (control):
  - bit0 flush: pointers and count to 0, contents not cleared.
  - bit1 clear ovf and unf.
  - bit2 sets inv, written every time.
  - bit0 and bit1 may be set together; both take effect in the same cycle.
- Read addr 2: {29'b0, inv, 2'b0}.
- Read addr 3: push counter. Write addr 3: push counter <= 0 regardless of data.
- Pointer wrap-around: from DEPTH-1 to 0. Full and empty are derived from count, never from pointer equality alone.
- Mid-operation rst: any in-flight strobe is discarded; the FIFO is empty in the following cycle.
- inv affects only the read path; changing inv reinterprets entries already stored.
- No back-pressure: ack is never withheld.

Decomposition:
- Shared include file echo_fifo_defs.vh holds:
  - address offsets (DATA 0, STAT 1, CTRL 2, PCNT 3)
  - status bit positions (EMPTY 16, FULL 17, OVF 18, UNF 19)
  - control bit positions (FLUSH 0, CLRERR 1, INV 2)
- One natural sub-module: fifo_buf (WIDTH, DEPTH), containing storage array, pointers, count, push/pop/flush inputs, head/full/empty outputs.
- echo_fifo wraps fifo_buf with bus decode, flags, mode and counter.

Test Plan:
- After rst, read status -> 0x00010000. Read data -> 0 and status then 0x00090000 (unf set).
- Write 0x1111, 0x2222, 0x3333 to addr 0; read addr 0 three times -> 0x1111, 0x2222, 0x3333. Status then 0x00090000; addr 3 reads 3.
- Write DEPTH+1 = 9 words 0xA0..0xA8 -> status 0x00060008; reads return 0xA0..0xA7; 0xA8 lost.
- Control write 0x4, write 0x00F0 to data, read data -> 0xFF0F (WIDTH=16). Data_in 0xDEAD_BEEF stored as 0xBEEF.
- With 5 words queued plus ovf/unf set, control write 0x3 -> status 0x00010000; next write/read pair returns the new word.
- Cycle 20 pushes/20 pops with DEPTH=8 to exercise pointer wrap; data order preserved.
- Assert rst during a data-write strobe -> entry not stored, count 0.
- Write addr 3 -> reads 0.
